// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM stage: FSM state encoding and parameter defaults.
package pwm_pkg;

    localparam int DEFAULT_CNT_W       = 8;
    localparam int DEFAULT_TOP         = 255;
    localparam int DEFAULT_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } pwm_state_t;

endpackage

// File: rtl/edge_tick_sync.sv
// Brings the asynchronous divider output into the clk domain and turns each
// rising edge into a single-cycle tick. SYNC_STAGES must be at least 2.
module edge_tick_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic a_in,
    output logic tick
);

    localparam int SETTLE_W = $clog2(SYNC_STAGES + 2);
    localparam logic [SETTLE_W-1:0] SETTLE_DONE = SETTLE_W'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0] chain;
    logic                   sync_prev;
    logic [SETTLE_W-1:0]    settle;
    logic                   settled;

    // Reset zeroes the chain, so an input held high across reset would look
    // like a fresh rise; ticks stay masked until the chain and edge register
    // hold real samples again.
    assign settled = (settle == SETTLE_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            chain     <= '0;
            sync_prev <= 1'b0;
            settle    <= '0;
        end else begin
            chain     <= {chain[SYNC_STAGES-2:0], a_in};
            sync_prev <= chain[SYNC_STAGES-1];
            if (!settled) begin
                settle <= settle + 1'b1;
            end
        end
    end

    assign tick = settled & chain[SYNC_STAGES-1] & ~sync_prev;

endmodule

// File: rtl/pwm_generator.sv
// PWM stage clocked by ticks from the divider; duty updates land only on
// period boundaries so the output never glitches mid-period.
module pwm_generator
    import pwm_pkg::*;
#(
    parameter int CNT_W       = DEFAULT_CNT_W,
    parameter int TOP         = DEFAULT_TOP,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_pwm,
    input  logic             enable,
    input  logic [CNT_W-1:0] duty_in,
    input  logic             duty_valid,
    output logic             duty_ready,
    output logic             pwm_out,
    output logic             period_end,
    output logic             busy,
    output logic [1:0]       fsm_state
);

    localparam logic [CNT_W-1:0] TOP_VAL = CNT_W'(TOP);

    pwm_state_t       state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [CNT_W-1:0] duty_active, duty_active_next;
    logic [CNT_W-1:0] duty_pending;
    logic             pending_valid;
    logic             tick, wrap, apply, capture, busy_next;

    edge_tick_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .a_in (a_pwm),
        .tick (tick)
    );

    // Handshake: a word transfers on any clk edge where duty_valid and
    // duty_ready are both high; the producer holds duty_in until then.
    assign duty_ready = ~pending_valid;
    assign capture    = duty_valid & duty_ready;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        wrap       = 1'b0;
        case (state)
            IDLE: begin
                cnt_next = '0;
                if (enable) state_next = RUN;
            end
            RUN, DRAIN: begin
                if (tick) begin
                    if (cnt == TOP_VAL) begin
                        cnt_next = '0;
                        wrap     = 1'b1;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
                if (state == RUN) begin
                    if (!enable) state_next = DRAIN;
                end else if (enable) begin
                    state_next = RUN;
                end else if (wrap) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
        apply            = pending_valid & (wrap | ((state == IDLE) & enable));
        duty_active_next = apply ? duty_pending : duty_active;
        busy_next        = (state_next != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            duty_active   <= '0;
            duty_pending  <= '0;
            pending_valid <= 1'b0;
            pwm_out       <= 1'b0;
            period_end    <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            duty_active <= duty_active_next;
            // A capture coinciding with an apply keeps the new word pending.
            if (capture) begin
                duty_pending  <= duty_in;
                pending_valid <= 1'b1;
            end else if (apply) begin
                pending_valid <= 1'b0;
            end
            pwm_out    <= busy_next & (cnt_next < duty_active_next);
            period_end <= wrap;
        end
    end

    assign busy      = (state != IDLE);
    assign fsm_state = state;

endmodule

// File: tb/tb_pwm_generator.sv
// Directed bench for pwm_generator with TOP=254 and a tick every 8 clk, so one
// PWM period spans 255*8 = 2040 clk and a duty of D gives 8*D high cycles.
module tb_pwm_generator;
    import pwm_pkg::*;

    localparam int TICK_CLKS  = 8;
    localparam int PERIOD_CLK = 255 * TICK_CLKS;

    logic       clk = 1'b0;
    logic       rst;
    logic       a_pwm;
    logic       enable;
    logic [7:0] duty_in;
    logic       duty_valid;
    logic       duty_ready;
    logic       pwm_out;
    logic       period_end;
    logic       busy;
    logic [1:0] fsm_state;

    logic       a_free  = 1'b1;
    logic       a_force = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] exp_q[$];

    pwm_generator #(
        .CNT_W       (8),
        .TOP         (254),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .a_pwm      (a_pwm),
        .enable     (enable),
        .duty_in    (duty_in),
        .duty_valid (duty_valid),
        .duty_ready (duty_ready),
        .pwm_out    (pwm_out),
        .period_end (period_end),
        .busy       (busy),
        .fsm_state  (fsm_state)
    );

    // clock / reset block
    always #5 clk = ~clk;

    // divider model: square wave toggling every 4 clk, or held at a_force
    initial begin
        int phase;
        phase = 0;
        a_pwm = 1'b0;
        forever begin
            @(negedge clk);
            if (a_free) begin
                phase++;
                if (phase == TICK_CLKS / 2) begin
                    phase = 0;
                    a_pwm = ~a_pwm;
                end
            end else begin
                a_pwm = a_force;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_duty(input logic [7:0] d);
        int i;
        duty_in    = d;
        duty_valid = 1'b1;
        for (i = 0; i < 4000 && !duty_ready; i++) @(negedge clk);
        check("send_ready", duty_ready, 1);
        @(negedge clk);
        duty_valid = 1'b0;
    endtask

    task automatic wait_pulse(input string tag);
        int i;
        for (i = 0; i < 4000 && !period_end; i++) @(negedge clk);
        check(tag, period_end, 1);
    endtask

    // Starts at the negedge of a period_end cycle, returns at the next one.
    task automatic measure(output int len, output int high, output int rises);
        logic prev;
        bit   done;
        len   = 0;
        high  = 0;
        rises = 0;
        prev  = pwm_out;
        done  = 1'b0;
        while (!done) begin
            if (pwm_out) high++;
            if (len > 0 && pwm_out && !prev) rises++;
            prev = pwm_out;
            len++;
            @(negedge clk);
            if (period_end || len > 2 * PERIOD_CLK) done = 1'b1;
        end
    endtask

    // scoreboard: expected high-cycle count per period comes off exp_q
    task automatic run_window(input string tag, input int exp_duty);
        int len, high, rises;
        exp_q.push_back(16'(exp_duty * TICK_CLKS));
        measure(len, high, rises);
        check({tag, "_len"}, len, PERIOD_CLK);
        check({tag, "_high"}, high, exp_q.pop_front());
        check({tag, "_glitch"}, rises, 0);
    endtask

    initial begin
        rst        = 1'b1;
        enable     = 1'b0;
        duty_in    = '0;
        duty_valid = 1'b0;
        wait_clks(3);
        rst = 1'b0;
        @(negedge clk);
        check("rst_pwm", pwm_out, 0);
        check("rst_pe", period_end, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", duty_ready, 1);
        check("rst_state", fsm_state, IDLE);

        // duty 64 pending in IDLE, applied on the IDLE->RUN transition
        send_duty(8'd64);
        check("pend_ready", duty_ready, 0);
        enable = 1'b1;
        @(negedge clk);
        check("start_ready", duty_ready, 1);
        check("start_busy", busy, 1);
        check("start_pwm", pwm_out, 1);
        check("start_state", fsm_state, RUN);
        wait_pulse("first_pulse");

        // new duty mid-period only takes effect after the wrap
        fork
            run_window("w64", 64);
            begin
                wait_clks(800);
                send_duty(8'd200);
                wait_clks(20);
                check("mid_ready0", duty_ready, 0);
                wait_clks(900);
                check("late_ready0", duty_ready, 0);
            end
        join
        check("wrap_ready1", duty_ready, 1);

        fork
            run_window("w200", 200);
            begin wait_clks(100); send_duty(8'd0); end
        join
        fork
            run_window("w0", 0);
            begin wait_clks(100); send_duty(8'd255); end
        join
        // 32 pending while 128 is held at the input through the wrap
        fork
            run_window("w255", 255);
            begin
                wait_clks(100);
                send_duty(8'd32);
                duty_in    = 8'd128;
                duty_valid = 1'b1;
            end
        join
        check("hold_ready1", duty_ready, 1);
        fork
            run_window("w32", 32);
            begin
                @(negedge clk);
                check("cap128_ready0", duty_ready, 0);
                duty_valid = 1'b0;
                wait_clks(500);
                check("pend128_ready0", duty_ready, 0);
            end
        join

        // enable dropped mid-period: drain to the wrap, then IDLE
        fork
            run_window("w128_drain", 128);
            begin wait_clks(800); enable = 1'b0; end
        join
        check("drain_busy", busy, 0);
        check("drain_pwm", pwm_out, 0);
        check("drain_state", fsm_state, IDLE);
        wait_clks(50);
        check("idle_busy", busy, 0);
        check("idle_pwm", pwm_out, 0);
        check("idle_pe", period_end, 0);

        // enable dropped then restored before the wrap: no return to IDLE
        enable = 1'b1;
        wait_pulse("restart_pulse");
        fork
            run_window("w128_resume", 128);
            begin
                wait_clks(800);
                enable = 1'b0;
                wait_clks(400);
                enable = 1'b1;
            end
        join
        check("resume_busy", busy, 1);
        check("resume_state", fsm_state, RUN);

        // reset mid-period with a pending word and a_pwm held high
        send_duty(8'd50);
        check("pre_rst_ready", duty_ready, 0);
        wait_clks(600);
        a_force = 1'b1;
        a_free  = 1'b0;
        enable  = 1'b0;
        wait_clks(3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mrst_pwm", pwm_out, 0);
        check("mrst_pe", period_end, 0);
        check("mrst_busy", busy, 0);
        check("mrst_ready", duty_ready, 1);
        check("mrst_state", fsm_state, IDLE);

        send_duty(8'd1);
        enable = 1'b1;
        @(negedge clk);
        check("post_rst_pwm", pwm_out, 1);
        wait_clks(100);
        check("no_spurious_tick", pwm_out, 1);
        check("held_busy", busy, 1);
        a_free = 1'b1;
        for (int i = 0; i < 40 && pwm_out; i++) @(negedge clk);
        check("tick_resumes", pwm_out, 0);

        enable = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
